fft8_controller: RTL and testbench
==================================

// Module: fft8_controller
// PURPOSE
//  Sequences one shared radix-2 butterfly through a full 8-point DIT FFT: 3 stages x 4 butterflies = 12 ops.
//  Holds an 8-entry complex sample buffer, filled by a valid/ready input stream in bit-reversed order.
//  Issues one butterfly op per cycle: operands out, results written back the same cycle.
//  Then streams the 8 bins out in natural order. Sits between the sample source and the result sink.
//  Butterfly and twiddle multiplier are external and purely combinational.
// PARAMETERS
//  N  3  log2 of sample word width; W = 2**N bits per real/imag component, two's complement
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  in_valid    in   1    input sample valid
//  in_ready    out  1    controller accepts a sample
//  in_r,in_i   in   W    input sample real/imag
//  out_valid   out  1    output bin valid
//  out_ready   in   1    sink accepts bin
//  out_r,out_i out  W    output bin real/imag
//  out_last    out  1    high with bin 7
//  busy        out  1    high in COMPUTE or UNLOAD
//  tw_idx      out  2    twiddle index k of W8^k for current op (to external multiplier on operand 2)
//  bf_in_1_r,bf_in_1_i   out W  butterfly operand 1 = buf[a]
//  bf_in_2_r,bf_in_2_i   out W  butterfly operand 2 = buf[b] (pre-twiddle)
//  bf_out_1_r,bf_out_1_i in  W  result a' (valid same cycle, combinational return)
//  bf_out_2_r,bf_out_2_i in  W  result b'
// BEHAVIOUR
//  Reset: state=LOAD, cnt=0, in_ready=1, out_valid=0, out_last=0, busy=0, tw_idx=0, bf_in_*=0, buffer=0.
//  LOAD: in_ready=1; on in_valid&&in_ready, buf[bitrev3(cnt)] <= in; cnt++.
//   8th handshake (cnt=7) -> COMPUTE, cnt=0, in_ready drops the next cycle.
//  COMPUTE: op j=cnt[1:0], stage s=cnt[3:2] (0..2), span=1<<s.
//   a = ((j>>s)<<(s+1)) | (j&(span-1)); b = a+span; tw_idx = (j&(span-1))<<(2-s).
//   Each cycle: buf[a]<=bf_out_1, buf[b]<=bf_out_2; cnt++.
//   Op 11 done -> UNLOAD, cnt=0. Exactly 12 cycles, no stalls.
//  Latency: last input accepted at edge t; ops on edges t+1..t+12; out_valid=1 after edge t+12.
//  bf_in_* and tw_idx are driven only in COMPUTE; forced 0 otherwise.
//  UNLOAD: out_valid=1, out=buf[cnt], out_last=(cnt==7).
//   Handshake out_valid&&out_ready -> cnt++. out_r/out_i hold stable while out_ready=0.
//   Bin 7 handshake -> LOAD, cnt=0, out_valid=0, in_ready=1 the next cycle.
//  Input is ignored outside LOAD (in_ready=0); out_ready is ignored outside UNLOAD.
//  Arithmetic: controller performs none; stores W-bit results as returned (modular wrap, no saturation/scaling).
//  Reset asserted mid-operation: immediate return to reset values; a partial frame is discarded.
//  No back-to-back overlap: a new frame loads only after bin 7 leaves.
// STRUCTURE
//  Shared package fft8_pkg:
//   - NPTS=8, LOG2N=3, NOPS=12
//   - state enum {LOAD, COMPUTE, UNLOAD}
//   - function bitrev3
//  Sub-module fft8_addr_gen (combinational): cnt[3:0] -> a, b, tw_idx.
//  Top: FSM, 4-bit counter, 8x(2W) register buffer with two write ports.
//  Top-level FFT instantiates this controller with the existing butterfly and twiddle multiplier.
// TESTING (W=8; bench wires butterfly + twiddle model: tw0=1, tw1=(1-j)/sqrt2 rounded, tw2=-j, tw3=(-1-j)/sqrt2)
//  1. Impulse x=(1,0,0,...,0) -> bins 0..7 all (1,0); out_last on bin 7 only.
//  2. DC x[k]=(1,0) for all k -> bin0=(8,0), bins 1..7=(0,0).
//  3. Op trace: (a,b,tw) per cycle = stage0 (0,1,0)(2,3,0)(4,5,0)(6,7,0);
//     stage1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage2 (0,4,0)(1,5,1)(2,6,2)(3,7,3).
//  4. Backpressure: out_ready=0 for 5 cycles at bin 3 -> out_valid stays 1, out_r/out_i stable, no bin skipped.
//  5. Reset pulse during COMPUTE cycle 6 -> next cycle in_ready=1, busy=0, out_valid=0;
//     a fresh impulse frame then yields all (1,0).
//  6. Wrap: x[0]=x[4]=(127,0), others 0 -> bin0=(-2,0) (254 wraps), bin1=(0,0); in_valid during COMPUTE is not accepted.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared constants, FSM state encoding and index helpers for the 8-point FFT controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft8_pkg;

    localparam int NPTS  = 8;   // points per frame
    localparam int LOG2N = 3;   // butterfly stages
    localparam int NOPS  = 12;  // butterflies per frame (LOG2N * NPTS/2)

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // Reverse the three bits of a sample index. The DIT schedule expects its
    // input in bit-reversed order, so natural-order samples are scattered
    // through this on the way into the buffer.
    function automatic logic [2:0] bitrev3(input logic [2:0] x);
        return {x[0], x[1], x[2]};
    endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Maps the op counter to the butterfly operand addresses and twiddle index.
// Latency: purely combinational.
// Backpressure: none; the caller only uses the outputs while computing.
//
// Ports:
//   cnt     in  4  op counter: [3:2] = stage, [1:0] = butterfly within stage
//   a       out 3  address of operand 1 (upper butterfly leg)
//   b       out 3  address of operand 2, always a + span
//   tw_idx  out 2  k of twiddle W8^k applied to operand 2
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [3:0] cnt,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [1:0] tw_idx
);

    logic [1:0] j;

    // Each stage is written out explicitly; the bit patterns are the general
    // a = ((j>>s)<<(s+1)) | (j & (span-1)) formula specialised per stage.
    always_comb begin
        j      = cnt[1:0];
        a      = 3'd0;
        b      = 3'd0;
        tw_idx = 2'd0;
        case (cnt[3:2])
            2'd0: begin  // span 1: adjacent pairs, all W8^0
                a      = {j, 1'b0};
                b      = {j, 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin  // span 2: pairs within each half, W8^0 / W8^2
                a      = {j[1], 1'b0, j[0]};
                b      = {j[1], 1'b1, j[0]};
                tw_idx = {j[0], 1'b0};
            end
            2'd2: begin  // span 4: pairs across halves, W8^j
                a      = {1'b0, j};
                b      = {1'b1, j};
                tw_idx = j;
            end
            default: begin
                a      = 3'd0;
                b      = 3'd0;
                tw_idx = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/fft8_controller.sv
// Sequences an external combinational butterfly through an 8-point radix-2 DIT FFT.
// Latency: 12 cycles of compute after the 8th sample is accepted, then 8 bins streamed out.
// Backpressure: in_ready only in LOAD; output bin holds while out_ready is low; no frame overlap.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         input sample handshake, in_r/in_i sample real/imag (W bits)
//   out_valid/out_ready       output bin handshake, out_r/out_i bin real/imag, out_last with bin 7
//   busy                      high while computing or unloading
//   tw_idx                    twiddle index for the external multiplier on operand 2
//   bf_in_1_*/bf_in_2_*       butterfly operands buf[a], buf[b] (zero outside compute)
//   bf_out_1_*/bf_out_2_*     butterfly results, written back to buf[a], buf[b] the same cycle
module fft8_controller
    import fft8_pkg::*;
#(
    parameter  int N = 3,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_r,
    input  logic [W-1:0] in_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic [W-1:0] out_i,
    output logic         out_last,
    output logic         busy,
    output logic [1:0]   tw_idx,
    output logic [W-1:0] bf_in_1_r,
    output logic [W-1:0] bf_in_1_i,
    output logic [W-1:0] bf_in_2_r,
    output logic [W-1:0] bf_in_2_i,
    input  logic [W-1:0] bf_out_1_r,
    input  logic [W-1:0] bf_out_1_i,
    input  logic [W-1:0] bf_out_2_r,
    input  logic [W-1:0] bf_out_2_i
);

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [W-1:0] mem_r [NPTS];
    logic [W-1:0] mem_i [NPTS];

    logic [2:0]   op_a;
    logic [2:0]   op_b;
    logic [1:0]   op_tw;

    logic         in_fire;
    logic         out_fire;
    logic         cnt_wrap;

    fft8_addr_gen u_addr_gen (
        .cnt    (cnt_q),
        .a      (op_a),
        .b      (op_b),
        .tw_idx (op_tw)
    );

    assign in_fire  = (state_q == LOAD) && in_valid;
    assign out_fire = (state_q == UNLOAD) && out_ready;

    // Last count of the current phase: 8 samples, 12 ops or 8 bins.
    always_comb begin
        cnt_wrap = 1'b0;
        case (state_q)
            LOAD:    cnt_wrap = (cnt_q == 4'(NPTS - 1));
            COMPUTE: cnt_wrap = (cnt_q == 4'(NOPS - 1));
            UNLOAD:  cnt_wrap = (cnt_q == 4'(NPTS - 1));
            default: cnt_wrap = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && cnt_wrap)  state_d = COMPUTE;
            COMPUTE: if (cnt_wrap)             state_d = UNLOAD;
            UNLOAD:  if (out_fire && cnt_wrap) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Output logic. Butterfly operands are forced to zero outside compute so
    // the external datapath sees a quiet bus while loading and unloading.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        tw_idx    = 2'd0;
        bf_in_1_r = '0;
        bf_in_1_i = '0;
        bf_in_2_r = '0;
        bf_in_2_i = '0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
            end
            COMPUTE: begin
                busy      = 1'b1;
                tw_idx    = op_tw;
                bf_in_1_r = mem_r[op_a];
                bf_in_1_i = mem_i[op_a];
                bf_in_2_r = mem_r[op_b];
                bf_in_2_i = mem_i[op_b];
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = cnt_wrap;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // The bin on the output follows the counter, which only moves on a
    // handshake, so the data is stable for as long as out_ready stays low.
    assign out_r = mem_r[cnt_q[2:0]];
    assign out_i = mem_i[cnt_q[2:0]];

    // Shared phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (in_fire || out_fire || (state_q == COMPUTE)) begin
            cnt_q <= cnt_wrap ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // Sample buffer. Loading uses one write port; compute uses two (a and b
    // never collide within an op). Results are stored as returned, so any
    // overflow in the external butterfly wraps modulo 2**W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPTS; i++) begin
                mem_r[i] <= '0;
                mem_i[i] <= '0;
            end
        end else if (in_fire) begin
            mem_r[bitrev3(cnt_q[2:0])] <= in_r;
            mem_i[bitrev3(cnt_q[2:0])] <= in_i;
        end else if (state_q == COMPUTE) begin
            mem_r[op_a] <= bf_out_1_r;
            mem_i[op_a] <= bf_out_1_i;
            mem_r[op_b] <= bf_out_2_r;
            mem_i[op_b] <= bf_out_2_i;
        end
    end

endmodule

// File: tb/tb_fft8_controller.sv
// Directed bench for fft8_controller with a butterfly + Q7 twiddle model on the side.
module tb_fft8_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] in_r, in_i;
    logic       out_valid, out_ready;
    logic [7:0] out_r, out_i;
    logic       out_last, busy;
    logic [1:0] tw_idx;
    logic [7:0] bf_in_1_r, bf_in_1_i, bf_in_2_r, bf_in_2_i;
    logic [7:0] bf_out_1_r, bf_out_1_i, bf_out_2_r, bf_out_2_i;

    int vectors = 0;
    int miscompares = 0;

    // When set, the butterfly returns its operands untouched so the buffer
    // keeps its loaded values and operand values identify addresses.
    logic bypass = 1'b0;

    logic [7:0] xr [8];
    logic [7:0] xi [8];
    logic [7:0] er [8];
    logic [7:0] ei [8];

    int a_exp  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b_exp  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tw_exp [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk = ~clk;

    fft8_controller dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_last   (out_last),
        .busy       (busy),
        .tw_idx     (tw_idx),
        .bf_in_1_r  (bf_in_1_r),
        .bf_in_1_i  (bf_in_1_i),
        .bf_in_2_r  (bf_in_2_r),
        .bf_in_2_i  (bf_in_2_i),
        .bf_out_1_r (bf_out_1_r),
        .bf_out_1_i (bf_out_1_i),
        .bf_out_2_r (bf_out_2_r),
        .bf_out_2_i (bf_out_2_i)
    );

    // Butterfly model: t = W8^k * op2 (Q7 twiddles, round half up), a' = op1 + t, b' = op1 - t.
    int m_wr, m_wi, m_tr, m_ti, m_ar, m_ai;
    always_comb begin
        case (tw_idx)
            2'd0:    begin m_wr = 128; m_wi = 0;    end
            2'd1:    begin m_wr = 91;  m_wi = -91;  end
            2'd2:    begin m_wr = 0;   m_wi = -128; end
            default: begin m_wr = -91; m_wi = -91;  end
        endcase
        m_ar = int'($signed(bf_in_1_r));
        m_ai = int'($signed(bf_in_1_i));
        m_tr = (int'($signed(bf_in_2_r)) * m_wr - int'($signed(bf_in_2_i)) * m_wi + 64) >>> 7;
        m_ti = (int'($signed(bf_in_2_r)) * m_wi + int'($signed(bf_in_2_i)) * m_wr + 64) >>> 7;
        if (bypass) begin
            bf_out_1_r = bf_in_1_r;
            bf_out_1_i = bf_in_1_i;
            bf_out_2_r = bf_in_2_r;
            bf_out_2_i = bf_in_2_i;
        end else begin
            bf_out_1_r = 8'(m_ar + m_tr);
            bf_out_1_i = 8'(m_ai + m_ti);
            bf_out_2_r = 8'(m_ar - m_tr);
            bf_out_2_i = 8'(m_ai - m_ti);
        end
    end

    // Feed xr/xi as one frame; returns just after the 8th accepting edge,
    // so the next falling edge is compute cycle 0.
    task automatic load_frame(input logic keep_valid);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL load_ready sample %0d: in_ready=%b busy=%b, want 1 0", k, in_ready, busy);
            end
            in_valid = 1'b1;
            in_r     = xr[k];
            in_i     = xi[k];
        end
        @(posedge clk);
        #1;
        in_valid = keep_valid;
    endtask

    // Consume the 8 bins and compare with er/ei; optionally hold out_ready low at one bin.
    task automatic drain(input int stall_bin, input int stall_len, input string tag);
        int guard;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            guard = 0;
            while (out_valid !== 1'b1 && guard < 32) begin
                @(negedge clk);
                guard++;
            end
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s out_valid timeout at bin %0d: got %b want 1", tag, n, out_valid);
                out_ready = 1'b0;
                return;
            end
            if (n == stall_bin) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_len; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (out_valid !== 1'b1 || out_r !== er[n] || out_i !== ei[n]) begin
                        miscompares++;
                        $display("FAIL %s stall bin %0d cycle %0d: valid=%b (%0d,%0d) want 1 (%0d,%0d)",
                                 tag, n, c, out_valid, $signed(out_r), $signed(out_i),
                                 $signed(er[n]), $signed(ei[n]));
                    end
                end
            end
            vectors++;
            if (out_r !== er[n] || out_i !== ei[n]) begin
                miscompares++;
                $display("FAIL %s bin %0d: got (%0d,%0d) want (%0d,%0d)", tag, n,
                         $signed(out_r), $signed(out_i), $signed(er[n]), $signed(ei[n]));
            end
            vectors++;
            if (out_last !== (n == 7)) begin
                miscompares++;
                $display("FAIL %s out_last bin %0d: got %b want %b", tag, n, out_last, (n == 7));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s return_to_load: valid=%b in_ready=%b busy=%b want 0 1 0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_last=%b busy=%b want 1 0 0 0",
                     in_ready, out_valid, out_last, busy);
        end
        vectors++;
        if (tw_idx !== 2'd0 || bf_in_1_r !== 8'd0 || bf_in_2_r !== 8'd0 || out_r !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data: tw=%0d bf1=%0d bf2=%0d out_r=%0d want 0 0 0 0",
                     tw_idx, bf_in_1_r, bf_in_2_r, out_r);
        end
        rst = 1'b0;
    endtask

    task automatic set_impulse();
        for (int k = 0; k < 8; k++) begin
            xr[k] = (k == 0) ? 8'd1 : 8'd0;
            xi[k] = 8'd0;
            er[k] = 8'd1;
            ei[k] = 8'd0;
        end
    endtask

    task automatic test_impulse();
        set_impulse();
        load_frame(1'b0);
        drain(-1, 0, "impulse");
    endtask

    task automatic test_dc();
        for (int k = 0; k < 8; k++) begin
            xr[k] = 8'd1;
            xi[k] = 8'd0;
            er[k] = (k == 0) ? 8'd8 : 8'd0;
            ei[k] = 8'd0;
        end
        load_frame(1'b0);
        drain(-1, 0, "dc");
    endtask

    // Input k lands in buf[bitrev(k)]; these values make buf[i] = i + 10.
    task automatic set_marker_frame();
        logic [7:0] marks [8];
        marks = '{8'd10, 8'd14, 8'd12, 8'd16, 8'd11, 8'd15, 8'd13, 8'd17};
        for (int k = 0; k < 8; k++) begin
            xr[k] = marks[k];
            xi[k] = 8'd0;
            er[k] = 8'(k + 10);
            ei[k] = 8'd0;
        end
    endtask

    task automatic test_op_trace();
        bypass = 1'b1;
        set_marker_frame();
        load_frame(1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL trace_ctrl op %0d: busy=%b out_valid=%b in_ready=%b want 1 0 0",
                         k, busy, out_valid, in_ready);
            end
            vectors++;
            if (bf_in_1_r !== 8'(a_exp[k] + 10) || bf_in_2_r !== 8'(b_exp[k] + 10) ||
                tw_idx !== 2'(tw_exp[k])) begin
                miscompares++;
                $display("FAIL trace_op %0d: got (a=%0d,b=%0d,tw=%0d) want (%0d,%0d,%0d)", k,
                         int'(bf_in_1_r) - 10, int'(bf_in_2_r) - 10, tw_idx,
                         a_exp[k], b_exp[k], tw_exp[k]);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || bf_in_1_r !== 8'd0 || tw_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL trace_latency: out_valid=%b bf1=%0d tw=%0d want 1 0 0",
                     out_valid, bf_in_1_r, tw_idx);
        end
        drain(-1, 0, "trace");
        bypass = 1'b0;
    endtask

    task automatic test_backpressure();
        bypass = 1'b1;
        set_marker_frame();
        load_frame(1'b0);
        drain(3, 5, "backpressure");
        bypass = 1'b0;
    endtask

    task automatic test_reset_mid_compute();
        set_impulse();
        for (int k = 0; k < 8; k++) xr[k] = 8'd5;
        load_frame(1'b0);
        for (int k = 0; k < 7; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || bf_in_1_r !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset: in_ready=%b busy=%b out_valid=%b bf1=%0d want 1 0 0 0",
                     in_ready, busy, out_valid, bf_in_1_r);
        end
        rst = 1'b0;
        set_impulse();
        load_frame(1'b0);
        drain(-1, 0, "post_reset");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) begin
            xr[k] = (k == 0 || k == 4) ? 8'd127 : 8'd0;
            xi[k] = 8'd0;
            er[k] = (k % 2 == 0) ? 8'hFE : 8'd0;
            ei[k] = 8'd0;
        end
        load_frame(1'b1);
        in_r = 8'd55;
        in_i = 8'd55;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_in_ready compute %0d: got %b want 0", k, in_ready);
            end
        end
        in_valid = 1'b0;
        drain(-1, 0, "wrap");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = 8'd0;
        in_i      = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_dc();
        test_op_trace();
        test_backpressure();
        test_reset_mid_compute();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
